// File: rtl/button_pkg.sv
// Shared types and constants for the button auto-repeat block.
//   state_t : hold-tracking state (IDLE, FIRST, REPEAT)
//   REP_MAX : saturation value of the repeat counter
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [7:0] REP_MAX = 8'd255;

endpackage

// File: rtl/button_repeater_if.sv
// Signal bundle between the debouncer side and the VGA control side.
//   boton        : debounced button level (driven by master)
//   pulso        : press / repeat event, one cycle
//   suelta       : release event, one cycle
//   mantenido    : a press is being tracked
//   conteo       : hold counter, N bits
//   repeticiones : repeats since last press, saturating at 255
// master drives the button; slave is the repeater itself.
interface button_repeater_if #(
    parameter int N = 8
);
    logic         boton;
    logic         pulso;
    logic         suelta;
    logic         mantenido;
    logic [N-1:0] conteo;
    logic [7:0]   repeticiones;

    modport master (
        output boton,
        input  pulso,
        input  suelta,
        input  mantenido,
        input  conteo,
        input  repeticiones
    );

    modport slave (
        input  boton,
        output pulso,
        output suelta,
        output mantenido,
        output conteo,
        output repeticiones
    );
endinterface

// File: rtl/button_repeater_edge_detector.sv
// Registers the button level and produces rise/fall strobes.
//   clk   : system clock
//   rst_n : synchronous reset, active-low
//   d     : button level
//   rise  : d is 1 now and was 0 on the previous edge
//   fall  : d is 0 now and was 1 on the previous edge
// The history register resets to 1 so a button held through reset is not
// mistaken for a fresh press.
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic d_q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q_reg <= 1'b1;
        end else begin
            d_q_reg <= d;
        end
    end

    assign rise = d & ~d_q_reg;
    assign fall = ~d & d_q_reg;
endmodule

// File: rtl/button_repeater.sv
// Turns a debounced button level into press, auto-repeat and release events.
//   clk   : system clock
//   rst_n : synchronous reset, active-low
//   bus   : button_repeater_if slave (boton in; pulso, suelta, mantenido,
//           conteo, repeticiones out; all outputs registered)
// Parameters: DELAY cycles from press pulse to first repeat, RATE cycles
// between repeats, N width of the hold counter.
module button_repeater
    import button_pkg::*;
#(
    parameter int DELAY = 200,
    parameter int RATE  = 50,
    parameter int N     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    button_repeater_if.slave   bus
);
    localparam logic [N-1:0] DELAY_LAST = N'(DELAY - 1);
    localparam logic [N-1:0] RATE_LAST  = N'(RATE - 1);

    state_t       state_reg;
    logic         pulso_reg;
    logic         suelta_reg;
    logic         mantenido_reg;
    logic [N-1:0] conteo_reg;
    logic [7:0]   rep_reg;

    logic         rise;
    logic         fall;
    logic [N-1:0] term_next;

    edge_detector u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.boton),
        .rise  (rise),
        .fall  (fall)
    );

    // Terminal count depends on whether we wait for the first repeat or a
    // subsequent one.
    assign term_next = (state_reg == FIRST) ? DELAY_LAST : RATE_LAST;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pulso_reg     <= 1'b0;
            suelta_reg    <= 1'b0;
            mantenido_reg <= 1'b0;
            conteo_reg    <= '0;
            rep_reg       <= '0;
        end else begin
            pulso_reg  <= 1'b0;
            suelta_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        pulso_reg     <= 1'b1;
                        conteo_reg    <= '0;
                        rep_reg       <= '0;
                        mantenido_reg <= 1'b1;
                        state_reg     <= FIRST;
                    end
                end
                FIRST, REPEAT: begin
                    // While tracking, the previous sample is always 1, so
                    // fall is exactly "button now low". Release is checked
                    // first so it beats a coincident terminal count.
                    if (fall) begin
                        suelta_reg    <= 1'b1;
                        conteo_reg    <= '0;
                        mantenido_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (conteo_reg == term_next) begin
                        pulso_reg  <= 1'b1;
                        conteo_reg <= '0;
                        if (rep_reg != REP_MAX) begin
                            rep_reg <= rep_reg + 8'd1;
                        end
                        state_reg  <= REPEAT;
                    end else begin
                        conteo_reg <= conteo_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    mantenido_reg <= 1'b0;
                    conteo_reg    <= '0;
                end
            endcase
        end
    end

    assign bus.pulso        = pulso_reg;
    assign bus.suelta       = suelta_reg;
    assign bus.mantenido    = mantenido_reg;
    assign bus.conteo       = conteo_reg;
    assign bus.repeticiones = rep_reg;
endmodule

// File: tb/tb_button_repeater.sv
// Testbench: dut_a (DELAY=10, RATE=4) and dut_b (DELAY=2, RATE=2) share a
// clock and reset, each with its own button input.
module tb_button_repeater;
    localparam int N  = 8;
    localparam int DA = 10;
    localparam int RA = 4;
    localparam int DB = 2;
    localparam int RB = 2;

    typedef struct packed {
        logic         p;
        logic         s;
        logic         m;
        logic [N-1:0] c;
        logic [7:0]   r;
    } outs_t;

    typedef struct {
        bit    b;
        bit    rn;
        outs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_repeater_if #(.N(N)) bus_a ();
    button_repeater_if #(.N(N)) bus_b ();

    button_repeater #(.DELAY(DA), .RATE(RA), .N(N)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    button_repeater #(.DELAY(DB), .RATE(RB), .N(N)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time since the press pulse decides everything.
    // Repeats fall at age DELAY, DELAY+RATE, DELAY+2*RATE, ...
    bit    m_held [2];
    bit    m_prev [2];
    int    m_age  [2];
    outs_t m_exp  [2];
    int    m_d    [2];
    int    m_r    [2];

    task automatic model_step(input int i, input bit b, input bit rn);
        outs_t e;
        int    a;
        int    k;
        e   = m_exp[i];
        e.p = 1'b0;
        e.s = 1'b0;
        if (!rn) begin
            e         = '0;
            m_held[i] = 1'b0;
            m_prev[i] = 1'b1;
        end else begin
            if (!m_held[i]) begin
                if (b && !m_prev[i]) begin
                    e.p = 1'b1; e.m = 1'b1; e.c = '0; e.r = '0;
                    m_held[i] = 1'b1;
                    m_age[i]  = 0;
                end
            end else if (!b) begin
                e.s = 1'b1; e.m = 1'b0; e.c = '0;
                m_held[i] = 1'b0;
            end else begin
                m_age[i] = m_age[i] + 1;
                a = m_age[i];
                if (a < m_d[i]) begin
                    e.c = N'(a);
                end else begin
                    k   = (a - m_d[i]) / m_r[i];
                    e.c = N'((a - m_d[i]) % m_r[i]);
                    e.r = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
                    e.p = ((a - m_d[i]) % m_r[i]) == 0;
                end
            end
            m_prev[i] = b;
        end
        m_exp[i] = e;
    endtask

    function automatic outs_t get_out(input int i);
        outs_t o;
        if (i == 0)
            o = '{bus_a.pulso, bus_a.suelta, bus_a.mantenido, bus_a.conteo, bus_a.repeticiones};
        else
            o = '{bus_b.pulso, bus_b.suelta, bus_b.mantenido, bus_b.conteo, bus_b.repeticiones};
        return o;
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got p=%0b s=%0b m=%0b c=%0d r=%0d, expected p=%0b s=%0b m=%0b c=%0d r=%0d",
                     name, act.p, act.s, act.m, act.c, act.r, exp.p, exp.s, exp.m, exp.c, exp.r);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample 1 time unit after the edge, compare
    // both DUTs against the model.
    task automatic step(input bit ba, input bit bb, input bit rn, input string tag);
        outs_t oa;
        outs_t ob;
        bus_a.boton = ba;
        bus_b.boton = bb;
        rst_n       = rn;
        @(posedge clk);
        #1;
        model_step(0, ba, rn);
        model_step(1, bb, rn);
        oa = get_out(0);
        ob = get_out(1);
        check({tag, "_model_a"}, oa, m_exp[0]);
        check({tag, "_model_b"}, ob, m_exp[1]);
        $display("%s rn=%0b ba=%0b bb=%0b | a: p=%0b s=%0b m=%0b c=%0d r=%0d | b: p=%0b s=%0b m=%0b c=%0d r=%0d",
                 tag, rn, ba, bb, oa.p, oa.s, oa.m, oa.c, oa.r, ob.p, ob.s, ob.m, ob.c, ob.r);
    endtask

    function automatic vec_t mk(input bit b, input bit rn, input bit p, input bit s,
                                input bit m, input int c, input int r);
        vec_t v;
        v.b = b; v.rn = rn;
        v.e = '{p, s, m, N'(c), 8'(r)};
        return v;
    endfunction

    initial begin
        vec_t  tbl [$];
        outs_t o;
        int    cnt;
        bit    ba;
        bit    bb;
        bit    rn;
        int    run_a;
        int    run_b;

        m_d = '{DA, DB};
        m_r = '{RA, RB};
        for (int i = 0; i < 2; i++) begin
            m_held[i] = 1'b0; m_prev[i] = 1'b1; m_age[i] = 0; m_exp[i] = '0;
        end
        bus_a.boton = 1'b0;
        bus_b.boton = 1'b0;

        // Expected sequences for dut_a (DELAY=10, RATE=4).
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        // press, count to terminal, first repeat, one more repeat
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0));
        for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 1, 0, 0, 1, i, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 1));
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(1, 1, 0, 0, 1, i, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 2));
        // release; repeticiones keeps its value
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 2));
        // immediate re-press, then a short tap
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        // release on the same edge as the first terminal count
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0));
        for (int i = 1; i <= 9; i++) tbl.push_back(mk(1, 1, 0, 0, 1, i, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].b, 1'b0, tbl[i].rn, "table");
            check("table_a", get_out(0), tbl[i].e);
        end

        // Reset while held: no pulse until a genuine new press.
        step(1, 0, 1, "hold");
        for (int i = 0; i < 5; i++) step(1, 0, 1, "hold");
        step(1, 1, 0, "rst_held");
        check("rst_held_a", get_out(0), outs_t'('0));
        check("rst_held_b", get_out(1), outs_t'('0));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, "post_rst");
            cnt += int'(bus_a.pulso) + int'(bus_b.pulso);
        end
        check_int("no_pulse_after_rst", cnt, 0);
        step(0, 0, 1, "release");
        step(1, 1, 1, "repress");
        check_int("repress_pulso_a", int'(bus_a.pulso), 1);
        check_int("repress_pulso_b", int'(bus_b.pulso), 1);
        step(0, 0, 1, "release");
        step(0, 0, 1, "idle");

        // Saturation on dut_b (DELAY=2, RATE=2).
        step(0, 1, 1, "sat_press");
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            step(0, 1, 1, "sat_hold");
            if (i >= 500) cnt += int'(bus_b.pulso);
        end
        check_int("sat_rep_b", int'(bus_b.repeticiones), 255);
        check_int("sat_pulse_rate_b", cnt, 50);
        step(0, 0, 1, "sat_release");
        check_int("sat_rep_hold_b", int'(bus_b.repeticiones), 255);

        // Random holds, taps and occasional resets.
        ba = 1'b0; bb = 1'b0; run_a = 0; run_b = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_a == 0) begin
                ba = ~ba;
                run_a = ba ? $urandom_range(1, 40) : $urandom_range(1, 6);
            end
            if (run_b == 0) begin
                bb = ~bb;
                run_b = bb ? $urandom_range(1, 12) : $urandom_range(1, 4);
            end
            run_a--;
            run_b--;
            rn = ($urandom_range(0, 199) != 0);
            step(ba, bb, rn, "rand");
            if (bus_a.pulso && bus_a.suelta) check_int("excl_a", 1, 0);
            if (bus_b.pulso && bus_b.suelta) check_int("excl_b", 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
